// File: rtl/accel_pkg.sv
// Shared accelerator definitions: default bias width and the bias-load controller
// state encoding.
package accel_pkg;

  localparam int ACCEL_BIAS_WIDTH = 32;

  typedef enum logic [1:0] {
    BL_IDLE,
    BL_FETCH,
    BL_DRAIN
  } bias_ld_state_e;

endpackage

// File: rtl/bias_load_ctrl.sv
// Fills a NUM_COLS-wide bias register bank from a synchronous bias ROM, hiding the ROM's
// one-cycle read latency and zero-filling columns beyond the layer's channel count.
module bias_load_ctrl
  import accel_pkg::*;
#(
  parameter int NUM_LAYERS   = 6,
  parameter int MAX_CHANNELS = 64,
  parameter int BIAS_WIDTH   = ACCEL_BIAS_WIDTH,
  parameter int NUM_COLS     = 4,
  localparam int LAYER_W     = $clog2(NUM_LAYERS),
  localparam int CH_W        = $clog2(MAX_CHANNELS),
  localparam int COL_W       = $clog2(NUM_COLS),
  localparam int CNT_W       = (COL_W > 0) ? COL_W : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [LAYER_W-1:0]             start_layer,
  input  logic [CH_W-1:0]                start_ch_base,
  input  logic [CH_W:0]                  start_num_ch,
  output logic                           busy,
  output logic                           done,
  output logic [LAYER_W-1:0]             rom_layer_sel,
  output logic [CH_W-1:0]                rom_addr,
  input  logic [BIAS_WIDTH-1:0]          rom_data,
  output logic [NUM_COLS*BIAS_WIDTH-1:0] bias_bank,
  output logic                           bias_valid
);

  bias_ld_state_e state_reg, state_next;

  logic [LAYER_W-1:0]             layer_reg;
  logic [CH_W-1:0]                base_reg;
  logic [CH_W:0]                  num_ch_reg;
  logic [CNT_W-1:0]               col_reg;
  logic                           cap_valid_reg;
  logic [CNT_W-1:0]               cap_idx_reg;
  logic                           cap_zero_reg;
  logic                           done_reg;
  logic                           bias_valid_reg;
  logic [NUM_COLS*BIAS_WIDTH-1:0] bank_reg;

  logic                           accept;
  logic                           fetch_en;
  logic                           last_col;
  logic [CH_W:0]                  ch_sum;
  logic                           col_masked;
  logic [NUM_COLS-1:0]            col_we;
  logic [BIAS_WIDTH-1:0]          cap_value;

  // One extra bit so base+k past the top channel is masked instead of wrapping.
  assign ch_sum     = {1'b0, base_reg} + (CH_W+1)'(col_reg);
  assign col_masked = (ch_sum >= num_ch_reg);
  assign last_col   = (col_reg == CNT_W'(NUM_COLS - 1));
  assign accept     = (state_reg == BL_IDLE) && start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= BL_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    busy          = 1'b0;
    fetch_en      = 1'b0;
    rom_layer_sel = '0;
    rom_addr      = '0;
    case (state_reg)
      BL_IDLE: begin
        if (start) begin
          state_next = BL_FETCH;
        end
      end
      BL_FETCH: begin
        busy          = 1'b1;
        fetch_en      = 1'b1;
        rom_layer_sel = layer_reg;
        rom_addr      = col_masked ? '0 : ch_sum[CH_W-1:0];
        if (last_col) begin
          state_next = BL_DRAIN;
        end
      end
      BL_DRAIN: begin
        busy       = 1'b1;
        state_next = BL_IDLE;
      end
      default: begin
        state_next = BL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      layer_reg      <= '0;
      base_reg       <= '0;
      num_ch_reg     <= '0;
      col_reg        <= '0;
      done_reg       <= 1'b0;
      bias_valid_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == BL_DRAIN);
      if (accept) begin
        layer_reg      <= start_layer;
        base_reg       <= start_ch_base;
        num_ch_reg     <= start_num_ch;
        col_reg        <= '0;
        bias_valid_reg <= 1'b0;
      end else begin
        if (fetch_en) begin
          col_reg <= last_col ? '0 : col_reg + CNT_W'(1);
        end
        if (state_reg == BL_DRAIN) begin
          bias_valid_reg <= 1'b1;
        end
      end
    end
  end

  // The capture pipe remembers which column the in-flight ROM read belongs to, so the
  // bank write one cycle later is independent of where the counter has moved on to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_valid_reg <= 1'b0;
      cap_idx_reg   <= '0;
      cap_zero_reg  <= 1'b0;
    end else begin
      cap_valid_reg <= fetch_en;
      cap_idx_reg   <= col_reg;
      cap_zero_reg  <= col_masked;
    end
  end

  assign cap_value = cap_zero_reg ? '0 : rom_data;

  generate
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col_we
      assign col_we[gi] = cap_valid_reg && (cap_idx_reg == CNT_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_reg <= '0;
    end else begin
      for (int k = 0; k < NUM_COLS; k++) begin
        if (col_we[k]) begin
          bank_reg[k*BIAS_WIDTH +: BIAS_WIDTH] <= cap_value;
        end
      end
    end
  end

  assign done       = done_reg;
  assign bias_valid = bias_valid_reg;
  assign bias_bank  = bank_reg;

endmodule
